load_store_unit: RTL

Core-side initiator for the word-addressed data memory. It accepts byte, halfword and word load/store requests from the execute stage and converts them into whole-word memory transactions. Loads use lane extraction with sign or zero extension. Sub-word stores use read-modify-write, because the memory has no byte enables. It sits between the pipeline's memory stage and the data memory, and it owns that memory's write-enable, address and write-data inputs.

---
 rtl/load_store_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator for a word-addressed memory without byte enables
module load_store_unit (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_ReqValid,
    output logic        o_ReqReady,
    input  logic        i_ReqWrite,
    input  logic [1:0]  i_ReqSize,
    input  logic        i_ReqUnsigned,
    input  logic [31:0] i_ReqAddress,
    input  logic [31:0] i_ReqWriteData,
    output logic        o_RespValid,
    output logic [31:0] o_RespData,
    output logic        o_RespError,
    output logic        o_MemWriteEnable,
    output logic [31:0] o_MemAddress,
    output logic [31:0] o_MemDataOut,
    input  logic [31:0] i_MemDataIn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state;
    state_t      state_next;

    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        write_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        misaligned;
    logic        word_store;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_result;
    logic [31:0] merged_word;

    // Upper address bits alias the 256 KiB window and are deliberately dropped.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^i_ReqAddress[31:18];

    assign accept     = i_ReqValid && (state == S_IDLE);
    assign word_store = write_q && (size_q == SIZE_WORD);

    always_comb begin
        misaligned = 1'b0;
        case (i_ReqSize)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = i_ReqAddress[0];
            SIZE_WORD: misaligned = |i_ReqAddress[1:0];
            default:   misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = misaligned ? S_RESP : S_ACCESS;
            S_ACCESS: state_next = word_store ? S_RESP : S_WAIT;
            S_WAIT:   state_next = write_q ? S_WRITE : S_RESP;
            S_WRITE:  state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Handshake and write strobe decode from state and latched request only.
    assign o_ReqReady       = (state == S_IDLE);
    assign o_RespValid      = (state == S_RESP);
    assign o_MemWriteEnable = ((state == S_ACCESS) && word_store) || (state == S_WRITE);

    always_comb begin
        byte_lane   = i_MemDataIn[7:0];
        half_lane   = lane_q[1] ? i_MemDataIn[31:16] : i_MemDataIn[15:0];
        load_result = i_MemDataIn;
        merged_word = i_MemDataIn;
        case (lane_q)
            2'd0:    byte_lane = i_MemDataIn[7:0];
            2'd1:    byte_lane = i_MemDataIn[15:8];
            2'd2:    byte_lane = i_MemDataIn[23:16];
            default: byte_lane = i_MemDataIn[31:24];
        endcase
        case (size_q)
            SIZE_BYTE: begin
                load_result = {{24{byte_lane[7] & ~unsigned_q}}, byte_lane};
                case (lane_q)
                    2'd0:    merged_word[7:0]   = wdata_q[7:0];
                    2'd1:    merged_word[15:8]  = wdata_q[7:0];
                    2'd2:    merged_word[23:16] = wdata_q[7:0];
                    default: merged_word[31:24] = wdata_q[7:0];
                endcase
            end
            SIZE_HALF: begin
                load_result = {{16{half_lane[15] & ~unsigned_q}}, half_lane};
                if (lane_q[1]) merged_word[31:16] = wdata_q;
                else           merged_word[15:0]  = wdata_q;
            end
            default: begin
                load_result = i_MemDataIn;
                merged_word = i_MemDataIn;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= S_IDLE;
            lane_q       <= 2'b0;
            size_q       <= 2'b0;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= 16'b0;
            o_RespData   <= 32'b0;
            o_RespError  <= 1'b0;
            o_MemAddress <= 32'b0;
            o_MemDataOut <= 32'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lane_q       <= i_ReqAddress[1:0];
                size_q       <= i_ReqSize;
                unsigned_q   <= i_ReqUnsigned;
                write_q      <= i_ReqWrite;
                wdata_q      <= i_ReqWriteData[15:0];
                o_RespData   <= 32'b0;
                o_RespError  <= misaligned;
                o_MemAddress <= {16'b0, i_ReqAddress[17:2]};
                if (i_ReqWrite) o_MemDataOut <= i_ReqWriteData;
            end
            if (state == S_WAIT) begin
                if (write_q) o_MemDataOut <= merged_word;
                else         o_RespData   <= load_result;
            end
        end
    end

endmodule
